// File: rtl/fp32_pkg.sv
// Shared FP32 adder types and constants.
// Used by the pre-add aligner and its sticky shifter.
package fp32_pkg;

    localparam int EXP_W     = 8;
    localparam int FRAC_W    = 23;
    localparam int MANT_W    = FRAC_W + 2;
    localparam int SHAMT_SAT = 27;
    localparam int SHAMT_W   = 5;

    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  eff_exp;
        logic [MANT_W-1:0] mant;
    } fp32_unpacked_t;

    typedef struct packed {
        logic [EXP_W-1:0]   eff_exp;
        logic [MANT_W-1:0]  m_big;
        logic [MANT_W-1:0]  m_small;
        logic [SHAMT_W-1:0] shamt;
        logic               sign_big;
        logic               sub;
        logic               special;
    } align_s1_t;

    typedef struct packed {
        logic [EXP_W-1:0]  eff_exp;
        logic [MANT_W-1:0] m_big;
        logic [MANT_W-1:0] m_small;
        logic [2:0]        grs;
        logic              sign_big;
        logic              sub;
        logic              special;
    } align_out_t;

    // Denormals get hidden=0 and the exponent frame of exp=1.
    function automatic fp32_unpacked_t unpack(input logic [31:0] x);
        fp32_unpacked_t u;
        logic [EXP_W-1:0] e;
        e         = x[FRAC_W+EXP_W-1:FRAC_W];
        u.sign    = x[31];
        u.eff_exp = (e == '0) ? EXP_W'(1) : e;
        u.mant    = {1'b0, (e != '0), x[FRAC_W-1:0]};
        return u;
    endfunction

endpackage

// File: rtl/sticky_shifter.sv
// Logarithmic right shifter for mantissa alignment.
// Bits shifted out are collapsed into guard/round/sticky.
module sticky_shifter
    import fp32_pkg::*;
(
    input  logic [MANT_W-1:0]  m_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic [MANT_W-1:0]  m_o,
    output logic [2:0]         grs_o
);

    // Mantissa sits above a field wide enough to catch a
    // saturated shift, so nothing is lost before the OR-reduce.
    localparam int W = MANT_W + SHAMT_SAT;

    logic [W-1:0] st [0:SHAMT_W];

    assign st[0] = {m_i, {SHAMT_SAT{1'b0}}};

    for (genvar i = 0; i < SHAMT_W; i++) begin : g_stage
        localparam int SH = 1 << i;
        assign st[i+1] = shamt_i[i] ? (st[i] >> SH) : st[i];
    end

    // Top field is the aligned mantissa; the next two bits are
    // guard and round; everything below folds into sticky.
    always_comb begin
        m_o   = st[SHAMT_W][W-1 -: MANT_W];
        grs_o = {st[SHAMT_W][SHAMT_SAT-1],
                 st[SHAMT_W][SHAMT_SAT-2],
                 |st[SHAMT_W][SHAMT_SAT-3:0]};
    end

endmodule

// File: rtl/addition_aligner.sv
// FP32 pre-add alignment: unpack, order by magnitude,
// right-shift the smaller mantissa with guard/round/sticky.
module addition_aligner
    import fp32_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_a,
    input  logic [31:0]        in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [EXP_W-1:0]   out_e,
    output logic [MANT_W-1:0]  out_m_big,
    output logic [MANT_W-1:0]  out_m_small,
    output logic [2:0]         out_grs,
    output logic               out_sign_big,
    output logic               out_sub,
    output logic               out_special
);

    fp32_unpacked_t    ua;
    fp32_unpacked_t    ub;
    fp32_unpacked_t    op_hi;
    fp32_unpacked_t    op_lo;
    logic              swap;
    logic [EXP_W-1:0]  diff;

    align_s1_t         s1_d;
    align_s1_t         s1_q;
    logic              s1_v_q;
    align_out_t        out_d;
    align_out_t        out_q;
    logic              s2_v_q;
    logic              s1_adv;

    logic [MANT_W-1:0] sh_m;
    logic [2:0]        sh_grs;

    assign s1_adv    = !s2_v_q || out_ready;
    assign in_ready  = !s1_v_q || s1_adv;
    assign out_valid = s2_v_q;

    // Unpack, order by magnitude and derive the saturated shift.
    always_comb begin
        ua    = unpack(in_a);
        ub    = unpack(in_b);
        swap  = (ub.eff_exp > ua.eff_exp) ||
                ((ub.eff_exp == ua.eff_exp) && (ub.mant > ua.mant));
        op_hi = swap ? ub : ua;
        op_lo = swap ? ua : ub;
        diff  = op_hi.eff_exp - op_lo.eff_exp;

        s1_d.eff_exp  = op_hi.eff_exp;
        s1_d.m_big    = op_hi.mant;
        s1_d.m_small  = op_lo.mant;
        s1_d.shamt    = (diff > EXP_W'(SHAMT_SAT)) ?
                        SHAMT_W'(SHAMT_SAT) : diff[SHAMT_W-1:0];
        s1_d.sign_big = op_hi.sign;
        s1_d.sub      = in_a[31] ^ in_b[31];
        s1_d.special  = (in_a[FRAC_W+EXP_W-1:FRAC_W] == EXP_SPECIAL) ||
                        (in_b[FRAC_W+EXP_W-1:FRAC_W] == EXP_SPECIAL);
    end

    // Stage 1 register: captures operands only on an accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            s1_q   <= '0;
        end else begin
            if (in_ready) s1_v_q <= in_valid;
            if (in_valid && in_ready) s1_q <= s1_d;
        end
    end

    sticky_shifter u_shift (
        .m_i     (s1_q.m_small),
        .shamt_i (s1_q.shamt),
        .m_o     (sh_m),
        .grs_o   (sh_grs)
    );

    // Stage 2 next state: aligned small mantissa plus GRS.
    always_comb begin
        out_d.eff_exp  = s1_q.eff_exp;
        out_d.m_big    = s1_q.m_big;
        out_d.m_small  = sh_m;
        out_d.grs      = sh_grs;
        out_d.sign_big = s1_q.sign_big;
        out_d.sub      = s1_q.sub;
        out_d.special  = s1_q.special;
    end

    // Stage 2 register: holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_q <= 1'b0;
            out_q  <= '0;
        end else begin
            if (s1_adv) s2_v_q <= s1_v_q;
            if (s1_v_q && s1_adv) out_q <= out_d;
        end
    end

    assign out_e        = out_q.eff_exp;
    assign out_m_big    = out_q.m_big;
    assign out_m_small  = out_q.m_small;
    assign out_grs      = out_q.grs;
    assign out_sign_big = out_q.sign_big;
    assign out_sub      = out_q.sub;
    assign out_special  = out_q.special;

endmodule
